// File: rtl/board_io_ctrl_pkg.sv
// Shared definitions for the board I/O conditioner: event code width and the
// event codes pushed toward the SoC.
package board_io_pkg;

    localparam int unsigned EVT_W = 4;

    typedef logic [EVT_W-1:0] evt_code_t;

    localparam evt_code_t EVT_BTN0_PRESS = 4'h1;
    localparam evt_code_t EVT_BTN0_REL   = 4'h2;
    localparam evt_code_t EVT_BTN1_PRESS = 4'h3;
    localparam evt_code_t EVT_BTN1_REL   = 4'h4;
    localparam evt_code_t EVT_DIP_CHG    = 4'h8;

endpackage

// File: rtl/board_io_ctrl_if.sv
// SoC-facing event/LED signal bundle; master is the SoC side, slave is the
// board_io_ctrl side.
interface board_io_ctrl_if;
    import board_io_pkg::*;

    logic             evt_valid;
    logic [EVT_W-1:0] evt_code;
    logic             evt_ready;
    logic             evt_ovf;
    logic             ovf_clr;
    logic             led_we;
    logic [6:0]       led_data;

    modport master (
        input  evt_valid, evt_code, evt_ovf,
        output evt_ready, ovf_clr, led_we, led_data
    );

    modport slave (
        output evt_valid, evt_code, evt_ovf,
        input  evt_ready, ovf_clr, led_we, led_data
    );

endinterface

// File: rtl/board_io_ctrl_debounce.sv
// Single-bit two-flop synchroniser plus counter debouncer; change_o pulses for
// one cycle, aligned with the first cycle stable_o shows its new value.
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic load_i,
    output logic stable_o,
    output logic change_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic          change_q, change_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = raw_i;
        s2_d     = s1_q;
        stable_d = stable_q;
        change_d = 1'b0;
        cnt_d    = '0;
        // A direct load takes the synced value silently, without a change pulse.
        if (load_i) begin
            stable_d = s2_q;
        end else if (s2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
                change_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= RST_VAL;
            s2_q     <= RST_VAL;
            stable_q <= RST_VAL;
            change_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            change_q <= change_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign change_o = change_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O conditioner: debounced buttons/DIPs, coded event FIFO toward the
// SoC with sticky overflow, and a SoC-writable LED register plus heartbeat.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 100000,
    parameter int unsigned HEARTBEAT_CYCLES = 5000000,
    parameter int unsigned EVT_DEPTH        = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       btn_n_i,
    input  logic [3:0]       dip_i,
    output logic [1:0]       btn_o,
    output logic [3:0]       dip_o,
    output logic             evt_valid_o,
    output logic [EVT_W-1:0] evt_code_o,
    input  logic             evt_ready_i,
    output logic             evt_ovf_o,
    input  logic             ovf_clr_i,
    input  logic             led_we_i,
    input  logic [6:0]       led_data_i,
    output logic [7:0]       led_o
);

    localparam int unsigned AW     = $clog2(EVT_DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned SU_END = DEBOUNCE_CYCLES + 3;
    localparam int unsigned SU_W   = $clog2(SU_END + 1);
    localparam int unsigned HB_W   = $clog2(HEARTBEAT_CYCLES);

    // ---------------- startup window ----------------
    logic [SU_W-1:0] su_cnt_q, su_cnt_d;
    logic            su_done, su_load;

    assign su_done = (su_cnt_q == SU_W'(SU_END));
    assign su_load = (su_cnt_q == SU_W'(SU_END - 1));

    always_comb su_cnt_d = su_done ? su_cnt_q : su_cnt_q + SU_W'(1);

    // ---------------- debouncers ----------------
    logic [1:0] btn_raw, btn_chg;
    logic [3:0] dip_chg;

    for (genvar g = 0; g < 2; g++) begin : g_btn
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .raw_i    (btn_n_i[g]),
            .load_i   (su_load),
            .stable_o (btn_raw[g]),
            .change_o (btn_chg[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_dip
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .raw_i    (dip_i[g]),
            .load_i   (su_load),
            .stable_o (dip_o[g]),
            .change_o (dip_chg[g])
        );
    end

    assign btn_o = ~btn_raw;

    // ---------------- pending events and arbitration ----------------
    logic [2:0]       src_chg;
    logic [EVT_W-1:0] src_code [3];
    logic [2:0]       pend_v_q, pend_v_d;
    logic [EVT_W-1:0] pend_c_q [3];
    logic [EVT_W-1:0] pend_c_d [3];
    logic [2:0]       grant;
    logic [EVT_W-1:0] push_code;
    logic             push, pop, full, can_push;
    logic             ovf_q, ovf_d, ovf_set;

    assign src_chg     = {|dip_chg, btn_chg} & {3{su_done}};
    assign src_code[0] = btn_o[0] ? EVT_BTN0_PRESS : EVT_BTN0_REL;
    assign src_code[1] = btn_o[1] ? EVT_BTN1_PRESS : EVT_BTN1_REL;
    assign src_code[2] = EVT_DIP_CHG;

    always_comb begin
        can_push = !full || pop;
        grant    = '0;
        if (can_push) begin
            if (pend_v_q[0])      grant = 3'b001;
            else if (pend_v_q[1]) grant = 3'b010;
            else if (pend_v_q[2]) grant = 3'b100;
        end
        push      = |grant;
        push_code = grant[0] ? pend_c_q[0] : (grant[1] ? pend_c_q[1] : pend_c_q[2]);

        pend_v_d = pend_v_q;
        pend_c_d = pend_c_q;
        ovf_set  = 1'b0;
        // A fresh transition overwrites the pending code; the granted (older)
        // code still goes to the FIFO this cycle.
        for (int unsigned i = 0; i < 3; i++) begin
            if (src_chg[i]) begin
                pend_v_d[i] = 1'b1;
                pend_c_d[i] = src_code[i];
                if (pend_v_q[i] && !grant[i] && full) ovf_set = 1'b1;
            end else if (grant[i]) begin
                pend_v_d[i] = 1'b0;
            end
        end

        ovf_d = ovf_set ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    // ---------------- event FIFO ----------------
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [EVT_W-1:0] mem_q [EVT_DEPTH];
    logic [EVT_W-1:0] mem_d [EVT_DEPTH];
    logic             empty;

    assign empty = (wr_q == rd_q);
    assign full  = ((wr_q - rd_q) == PW'(EVT_DEPTH));
    assign pop   = evt_valid_o && evt_ready_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_code;
            wr_d                = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);
    end

    assign evt_valid_o = !empty;
    assign evt_code_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign evt_ovf_o   = ovf_q;

    // ---------------- LEDs ----------------
    logic [6:0]      led_q, led_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            hb_q, hb_d;
    logic            hb_wrap;

    assign hb_wrap = (hb_cnt_q == HB_W'(HEARTBEAT_CYCLES - 1));

    always_comb begin
        led_d    = led_we_i ? led_data_i : led_q;
        hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + HB_W'(1);
        hb_d     = hb_wrap ? ~hb_q : hb_q;
    end

    assign led_o = {hb_q, led_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            su_cnt_q <= '0;
            pend_v_q <= '0;
            pend_c_q <= '{default: '0};
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            mem_q    <= '{default: '0};
            led_q    <= '0;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            su_cnt_q <= su_cnt_d;
            pend_v_q <= pend_v_d;
            pend_c_q <= pend_c_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            mem_q    <= mem_d;
            led_q    <= led_d;
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with DEBOUNCE_CYCLES=8, HEARTBEAT_CYCLES=16.
module tb_board_io_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_n;
    logic [3:0] dip;
    logic [1:0] btn_o;
    logic [3:0] dip_o;
    logic [7:0] led_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    board_io_ctrl_if bus ();

    always #5 clk = ~clk;

    board_io_ctrl #(
        .DEBOUNCE_CYCLES  (8),
        .HEARTBEAT_CYCLES (16),
        .EVT_DEPTH        (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_n_i     (btn_n),
        .dip_i       (dip),
        .btn_o       (btn_o),
        .dip_o       (dip_o),
        .evt_valid_o (bus.evt_valid),
        .evt_code_o  (bus.evt_code),
        .evt_ready_i (bus.evt_ready),
        .evt_ovf_o   (bus.evt_ovf),
        .ovf_clr_i   (bus.ovf_clr),
        .led_we_i    (bus.led_we),
        .led_data_i  (bus.led_data),
        .led_o       (led_o)
    );

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (bus.evt_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 8'(bus.evt_valid), 8'h01);
    endtask

    task automatic pop();
        bus.evt_ready = 1'b1;
        tick(1);
        bus.evt_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        btn_n         = 2'b11;
        dip           = 4'b1010;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.led_we    = 1'b0;
        bus.led_data  = '0;
        tick(3);

        chk("rst_btn",   8'(btn_o), 8'h00);
        chk("rst_dip",   8'(dip_o), 8'h00);
        chk("rst_valid", 8'(bus.evt_valid), 8'h00);
        chk("rst_code",  8'(bus.evt_code), 8'h00);
        chk("rst_ovf",   8'(bus.evt_ovf), 8'h00);
        chk("rst_led",   led_o, 8'h00);

        // 1: DIP held through reset, startup window suppresses the event
        rst = 1'b0;
        tick(11);
        chk("su_dip",    8'(dip_o), 8'h0A);
        chk("su_valid",  8'(bus.evt_valid), 8'h00);
        tick(5);
        chk("su_valid2", 8'(bus.evt_valid), 8'h00);
        chk("su_btn",    8'(btn_o), 8'h00);

        // 2: btn0 press, latency 10 cycles, then release
        btn_n[0] = 1'b0;
        tick(9);
        chk("b0_early", 8'(btn_o), 8'h00);
        tick(1);
        chk("b0_lat", 8'(btn_o), 8'h01);
        wait_valid("b0_valid", 4);
        chk("b0_code", 8'(bus.evt_code), 8'h01);
        btn_n[0] = 1'b1;
        tick(10);
        chk("b0_rel", 8'(btn_o), 8'h00);
        tick(3);
        chk("b0_hold", 8'(bus.evt_code), 8'h01);
        pop();
        chk("b0_rel_valid", 8'(bus.evt_valid), 8'h01);
        chk("b0_rel_code",  8'(bus.evt_code), 8'h02);
        pop();
        chk("b0_empty", 8'(bus.evt_valid), 8'h00);

        // 3: short glitch on btn1 ignored, 8-cycle pulse accepted
        btn_n[1] = 1'b0;
        tick(5);
        btn_n[1] = 1'b1;
        tick(15);
        chk("glitch_btn",   8'(btn_o), 8'h00);
        chk("glitch_valid", 8'(bus.evt_valid), 8'h00);
        btn_n[1] = 1'b0;
        tick(8);
        btn_n[1] = 1'b1;
        tick(2);
        chk("b1_min", 8'(btn_o), 8'h02);
        wait_valid("b1_valid", 4);
        chk("b1_code", 8'(bus.evt_code), 8'h03);
        tick(14);
        pop();
        chk("b1_rel_code", 8'(bus.evt_code), 8'h04);
        pop();
        chk("b1_empty", 8'(bus.evt_valid), 8'h00);

        // 4: six events into a 4-deep FIFO with no reads
        for (int unsigned i = 0; i < 3; i++) begin
            btn_n[0] = 1'b0;
            tick(12);
            btn_n[0] = 1'b1;
            tick(12);
        end
        tick(2);
        chk("ovf_valid", 8'(bus.evt_valid), 8'h01);
        chk("ovf_head",  8'(bus.evt_code), 8'h01);
        chk("ovf_set",   8'(bus.evt_ovf), 8'h01);
        bus.ovf_clr = 1'b1;
        tick(1);
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", 8'(bus.evt_ovf), 8'h00);
        pop();
        chk("drain1", 8'(bus.evt_code), 8'h02);
        pop();
        chk("drain2", 8'(bus.evt_code), 8'h01);
        pop();
        chk("drain3", 8'(bus.evt_code), 8'h02);
        pop();
        chk("drain4", 8'(bus.evt_code), 8'h02);
        pop();
        chk("drain_empty", 8'(bus.evt_valid), 8'h00);

        // 5: btn0 press and DIP change settle together; btn0 wins
        btn_n[0] = 1'b0;
        dip      = 4'b0101;
        wait_valid("arb_valid", 16);
        chk("arb_first", 8'(bus.evt_code), 8'h01);
        chk("arb_dip",   8'(dip_o), 8'h05);
        tick(3);
        chk("arb_hold", 8'(bus.evt_code), 8'h01);
        pop();
        chk("arb_second", 8'(bus.evt_code), 8'h08);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", 8'(bus.evt_valid), 8'h00);
        chk("mid_rst_btn",   8'(btn_o), 8'h00);
        chk("mid_rst_dip",   8'(dip_o), 8'h00);
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("re_su_btn",   8'(btn_o), 8'h01);
        chk("re_su_dip",   8'(dip_o), 8'h05);
        chk("re_su_valid", 8'(bus.evt_valid), 8'h00);
        btn_n[0] = 1'b1;
        wait_valid("re_rel_valid", 16);
        chk("re_rel_code", 8'(bus.evt_code), 8'h02);
        pop();
        chk("re_empty", 8'(bus.evt_valid), 8'h00);

        // 6: LED register write and heartbeat period
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("led_rst", led_o, 8'h00);
        tick(15);
        chk("hb_pre", led_o, 8'h00);
        bus.led_we   = 1'b1;
        bus.led_data = 7'h55;
        tick(1);
        bus.led_we = 1'b0;
        chk("led_wr_hb1", led_o, 8'hD5);
        tick(15);
        chk("hb_hold", led_o, 8'hD5);
        tick(1);
        chk("hb_toggle", led_o, 8'h55);
        bus.led_data = 7'h2A;
        tick(1);
        chk("led_no_we", led_o, 8'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
